det_event_monitor: RTL and testbench



---
 rtl/det_event_monitor.sv | 170 +++++++++++++++++
 tb/tb_det_event_monitor.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/det_event_monitor.sv
// Event monitor for the sequence detector's Mealy det output:
// registers det, counts rising edges, measures spacing, raises a window alarm.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset
//   det       raw (possibly glitchy) detection flag
//   clr       synchronous clear of counters, gap and alarm
//   event_cnt saturating total event count
//   last_gap  cycles between the two most recent events (saturating)
//   gap_valid last_gap holds a real measurement
//   alarm     sticky threshold flag, equals (state == ALARM)
//   state     FSM state: IDLE=00, WIN=01, ALARM=10

module det_event_monitor #(
    parameter int CNT_W  = 8,
    parameter int GAP_W  = 8,
    parameter int WINDOW = 16,
    parameter int THRESH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             det,
    input  logic             clr,
    output logic [CNT_W-1:0] event_cnt,
    output logic [GAP_W-1:0] last_gap,
    output logic             gap_valid,
    output logic             alarm,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WIN   = 2'b01,
        ALARM = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W:0]   THR      = (CNT_W+1)'(THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [GAP_W-1:0] GAP_MAX  = '1;

    // input stage
    logic det_q;
    logic det_d;
    logic ev;

    // gap measurement
    logic [GAP_W-1:0] gap_timer;
    logic             seen;

    // window FSM
    state_t           state_q;
    state_t           state_n;
    logic [CNT_W-1:0] win_timer;
    logic [CNT_W-1:0] win_timer_n;
    logic [CNT_W-1:0] win_evt;
    logic [CNT_W-1:0] win_evt_n;
    logic [CNT_W:0]   win_evt_inc;
    logic             thresh_hit;

    // det is registered twice so a glitch on the combinational Mealy
    // output cannot reach the counters; ev is the clean rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            det_q <= 1'b0;
            det_d <= 1'b0;
        end else begin
            det_q <= det;
            det_d <= det_q;
        end
    end

    assign ev = det_q & ~det_d;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            event_cnt <= '0;
        end else if (ev && event_cnt != CNT_MAX) begin
            event_cnt <= event_cnt + CNT_W'(1);
        end
    end

    // The timer reloads to 1 on each event so that, one edge later,
    // it already reads the distance in edges from that event.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            gap_timer <= '0;
            last_gap  <= '0;
            gap_valid <= 1'b0;
            seen      <= 1'b0;
        end else if (ev) begin
            gap_timer <= GAP_W'(1);
            seen      <= 1'b1;
            if (seen) begin
                last_gap  <= gap_timer;
                gap_valid <= 1'b1;
            end
        end else if (gap_timer != GAP_MAX) begin
            gap_timer <= gap_timer + GAP_W'(1);
        end
    end

    // one extra bit so win_evt+1 cannot wrap before the compare
    assign win_evt_inc = {1'b0, win_evt} + (CNT_W+1)'(1);
    assign thresh_hit  = (win_evt_inc >= THR);

    always_comb begin
        state_n     = state_q;
        win_timer_n = win_timer;
        win_evt_n   = win_evt;
        case (state_q)
            IDLE: begin
                if (ev) begin
                    if (THRESH == 1) begin
                        state_n = ALARM;
                    end else begin
                        state_n     = WIN;
                        win_timer_n = WIN_LOAD;
                        win_evt_n   = CNT_W'(1);
                    end
                end
            end
            WIN: begin
                if (ev && thresh_hit) begin
                    state_n = ALARM;
                end else if (win_timer == '0) begin
                    if (ev) begin
                        // the boundary event opens the next window
                        win_timer_n = WIN_LOAD;
                        win_evt_n   = CNT_W'(1);
                    end else begin
                        state_n   = IDLE;
                        win_evt_n = '0;
                    end
                end else begin
                    if (ev) begin
                        win_evt_n = win_evt_inc[CNT_W-1:0];
                    end
                    win_timer_n = win_timer - CNT_W'(1);
                end
            end
            ALARM: begin
                state_n = ALARM;
            end
            default: begin
                state_n     = IDLE;
                win_timer_n = '0;
                win_evt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            state_q   <= IDLE;
            win_timer <= '0;
            win_evt   <= '0;
            alarm     <= 1'b0;
        end else begin
            state_q   <= state_n;
            win_timer <= win_timer_n;
            win_evt   <= win_evt_n;
            alarm     <= (state_n == ALARM);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_det_event_monitor.sv
// Self-checking bench for det_event_monitor: directed scenarios plus
// random det/clr/reset traffic against a time-based reference model.

module tb_det_event_monitor;

    localparam int CNT_W  = 8;
    localparam int GAP_W  = 8;
    localparam int WINDOW = 16;
    localparam int THRESH = 3;
    localparam int CMAX   = (1 << CNT_W) - 1;
    localparam int GMAX   = (1 << GAP_W) - 1;

    logic             clk;
    logic             reset;
    logic             det;
    logic             clr;
    logic [CNT_W-1:0] event_cnt;
    logic [GAP_W-1:0] last_gap;
    logic             gap_valid;
    logic             alarm;
    logic [1:0]       state;

    det_event_monitor #(
        .CNT_W (CNT_W),
        .GAP_W (GAP_W),
        .WINDOW(WINDOW),
        .THRESH(THRESH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .det      (det),
        .clr      (clr),
        .event_cnt(event_cnt),
        .last_gap (last_gap),
        .gap_valid(gap_valid),
        .alarm    (alarm),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model: events are timestamps, windows are time spans
    bit m_p1, m_p2;
    int m_cnt, m_gap, m_last;
    bit m_seen, m_gv, m_alarm;
    bit m_win;
    int m_wstart, m_wcnt;

    task automatic m_clear();
        m_cnt   = 0;
        m_gap   = 0;
        m_last  = 0;
        m_seen  = 0;
        m_gv    = 0;
        m_alarm = 0;
        m_win   = 0;
        m_wstart = 0;
        m_wcnt  = 0;
    endtask

    task automatic m_window(input int t);
        if (m_alarm) return;
        if (!m_win || t > m_wstart + WINDOW) begin
            if (THRESH == 1) begin
                m_alarm = 1;
            end else begin
                m_win = 1; m_wstart = t; m_wcnt = 1;
            end
        end else if (m_wcnt + 1 >= THRESH) begin
            m_alarm = 1;
        end else if (t == m_wstart + WINDOW) begin
            m_wstart = t; m_wcnt = 1;
        end else begin
            m_wcnt++;
        end
    endtask

    task automatic m_edge(input bit d, input bit c, input bit r,
                          input int t);
        bit ev;
        if (r) begin
            m_clear();
            m_p1 = 0; m_p2 = 0;
            return;
        end
        ev   = m_p1 && !m_p2;
        m_p2 = m_p1;
        m_p1 = d;
        if (c) begin
            m_clear();
        end else if (ev) begin
            if (m_cnt < CMAX) m_cnt++;
            if (m_seen) begin
                m_gap = (t - m_last > GMAX) ? GMAX : t - m_last;
                m_gv  = 1;
            end
            m_seen = 1;
            m_last = t;
            m_window(t);
        end
    endtask

    function automatic int m_state(input int t);
        if (m_alarm) return 2;
        if (m_win && t < m_wstart + WINDOW) return 1;
        return 0;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d obs=%0d exp=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input bit d, input bit c, input bit r);
        @(negedge clk);
        det   = d;
        clr   = c;
        reset = r;
        @(posedge clk);
        cyc++;
        m_edge(d, c, r, cyc);
        #1;
        chk("event_cnt", int'(event_cnt), m_cnt);
        chk("last_gap", int'(last_gap), m_gap);
        chk("gap_valid", int'(gap_valid), int'(m_gv));
        chk("alarm", int'(alarm), int'(m_alarm));
        chk("state", int'(state), m_state(cyc));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    initial begin
        det   = 1'b0;
        clr   = 1'b0;
        reset = 1'b1;
        m_clear();
        m_p1 = 0; m_p2 = 0;

        step(0, 0, 1);
        step(0, 0, 1);
        chk("rst_cnt", int'(event_cnt), 0);
        chk("rst_state", int'(state), 0);

        // single pulse: det at edge 10, ev at 11, window ends at 27
        idle(9);
        step(1, 0, 0);
        step(0, 0, 0);
        chk("p2_cnt", int'(event_cnt), 1);
        chk("p2_state_win", int'(state), 1);
        chk("p2_gv", int'(gap_valid), 0);
        idle(15);
        chk("p2_state_26", int'(state), 1);
        idle(1);
        chk("p2_state_27", int'(state), 0);

        // three pulses at relative edges 0, 3, 10
        step(0, 1, 0);
        step(1, 0, 0);
        idle(2);
        step(1, 0, 0);
        step(0, 0, 0);
        chk("p3_cnt2", int'(event_cnt), 2);
        chk("p3_gap3", int'(last_gap), 3);
        idle(5);
        step(1, 0, 0);
        step(0, 0, 0);
        chk("p3_cnt3", int'(event_cnt), 3);
        chk("p3_gap7", int'(last_gap), 7);
        chk("p3_alarm", int'(alarm), 1);
        chk("p3_state", int'(state), 2);
        idle(100);
        chk("p3_sticky", int'(alarm), 1);

        // clr lands on the same edge the event is recognised
        step(1, 0, 0);
        step(0, 1, 0);
        chk("p6_cnt", int'(event_cnt), 0);
        chk("p6_gv", int'(gap_valid), 0);
        chk("p6_alarm", int'(alarm), 0);
        chk("p6_state", int'(state), 0);
        idle(3);
        chk("p6_dropped", int'(event_cnt), 0);

        // pulses every 20 cycles never share a window
        step(0, 1, 0);
        for (int p = 0; p < 5; p++) begin
            step(1, 0, 0);
            idle(19);
        end
        chk("p4_alarm", int'(alarm), 0);
        chk("p4_cnt", int'(event_cnt), 5);
        chk("p4_gap", int'(last_gap), 20);
        chk("p4_gv", int'(gap_valid), 1);
        chk("p4_state", int'(state), 0);

        // a held level is one event
        step(0, 1, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0);
        idle(3);
        chk("p5_level", int'(event_cnt), 1);

        // event on the exact window boundary opens a new window
        step(0, 1, 0);
        step(1, 0, 0);
        idle(15);
        step(1, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        idle(2);
        chk("bnd_alarm", int'(alarm), 0);
        chk("bnd_state", int'(state), 1);
        idle(20);

        // saturation of event_cnt
        step(0, 1, 0);
        for (int p = 0; p < 300; p++) begin
            step(1, 0, 0);
            idle(39);
        end
        chk("p5_sat", int'(event_cnt), 255);
        chk("p5_gap40", int'(last_gap), 40);

        // reset mid-run with nonzero counters
        step(1, 0, 0);
        step(0, 0, 1);
        chk("p1_cnt", int'(event_cnt), 0);
        chk("p1_gap", int'(last_gap), 0);
        chk("p1_gv", int'(gap_valid), 0);
        chk("p1_alarm", int'(alarm), 0);
        chk("p1_state", int'(state), 0);
        step(0, 0, 1);
        idle(2);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 3) == 0,
                 $urandom_range(0, 79) == 0,
                 $urandom_range(0, 599) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
